// File: rtl/pkg_pipeline.sv
// Shared pipeline types: EX->WB record, control opcodes,
// and the architectural register count.
package pkg_pipeline;

  localparam int NREG = 16;

  localparam logic [7:0] OP_MULDIV = 8'd247;
  localparam logic [7:0] OP_PUSH   = 8'd255;
  localparam logic [7:0] OP_STORE  = 8'd137;
  localparam logic [7:0] OP_LOAD   = 8'd139;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] alu_result;
    logic [63:0] alu_ext_result;
    logic [7:0]  opcode;
    logic [3:0]  reg_byte;
    logic [3:0]  rm_byte;
    logic        sim_end;
  } EX_WB;

endpackage

// File: rtl/mod_dest_decode.sv
// Destination decode: opcode/reg/rm -> register write mask.
// Ports: opcode, reg_byte, rm_byte in; mask (NREG bits) out.
module mod_dest_decode
  import pkg_pipeline::*;
#(
  parameter int NREG = pkg_pipeline::NREG
) (
  input  logic [7:0]      opcode,
  input  logic [3:0]      reg_byte,
  input  logic [3:0]      rm_byte,
  output logic [NREG-1:0] mask
);

  always_comb begin
    mask = '0;
    unique case (1'b1)
      opcode == OP_MULDIV: begin
        mask[0] = 1'b1;
        mask[2] = 1'b1;
      end
      opcode == OP_PUSH:  mask[4] = 1'b1;
      opcode == OP_STORE: mask = '0;
      opcode == OP_LOAD:
        mask = NREG'(1) << reg_byte;
      default:
        mask = NREG'(1) << rm_byte;
    endcase
  end

endmodule

// File: rtl/mod_exwb_issue.sv
// EX->WB transmit buffer: FIFO of execute results for writeback.
// Ports: ex_* push side, wb_ready/can_writeback/exwb pop side,
// flush, dep_exwb occupancy, dest_busy pending-dest mask.
module mod_exwb_issue
  import pkg_pipeline::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = pkg_pipeline::NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [63:0]     ex_pc,
  input  logic [63:0]     ex_alu_result,
  input  logic [63:0]     ex_alu_ext_result,
  input  logic [7:0]      ex_opcode,
  input  logic [3:0]      ex_regByte,
  input  logic [3:0]      ex_rmByte,
  input  logic            ex_sim_end,
  input  logic            flush,
  input  logic            wb_ready,
  output logic            can_writeback,
  output EX_WB            exwb,
  output logic [1:0]      dep_exwb,
  output logic [NREG-1:0] dest_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  EX_WB             mem [DEPTH];
  EX_WB             ent_in;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_nxt;
  logic [PW-1:0]    rd_nxt;
  logic [PW-1:0]    occ;
  logic [PW-1:0]    occ_nxt;
  logic [1:0]       dep_q;
  logic [1:0]       dep_nxt;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             end_seen;
  logic             end_buf;
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_end;
  logic [NREG-1:0]  ent_mask [DEPTH];

  assign ent_in = '{
    pc:             ex_pc,
    alu_result:     ex_alu_result,
    alu_ext_result: ex_alu_ext_result,
    opcode:         ex_opcode,
    reg_byte:       ex_regByte,
    rm_byte:        ex_rmByte,
    sim_end:        ex_sim_end
  };

  assign occ   = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign ex_ready      = !reset && !full && !end_seen;
  assign can_writeback = !empty;
  assign exwb          = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign dep_exwb      = dep_q;

  // flush overrides both sides of the handshake
  assign push = ex_valid && ex_ready && !flush;
  assign pop  = can_writeback && wb_ready && !flush;

  // flush empties by pulling the read pointer up to the write pointer
  assign wr_nxt  = wr_ptr + PW'(push);
  assign rd_nxt  = flush ? wr_ptr : rd_ptr + PW'(pop);
  assign occ_nxt = wr_nxt - rd_nxt;

  always_comb begin
    dep_nxt = occ_nxt[1:0];
    if (occ_nxt > PW'(3))
      dep_nxt = 2'd3;
  end

  // slot i is live when its distance from the head is below occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    assign off        = AW'(i) - rd_ptr[AW-1:0];
    assign ent_vld[i] = {1'b0, off} < occ;
    assign ent_end[i] = ent_vld[i] && mem[i].sim_end;

    mod_dest_decode #(
      .NREG(NREG)
    ) u_dec (
      .opcode  (mem[i].opcode),
      .reg_byte(mem[i].reg_byte),
      .rm_byte (mem[i].rm_byte),
      .mask    (ent_mask[i])
    );
  end

  assign end_buf = |ent_end;

  always_comb begin
    dest_busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i])
        dest_busy = dest_busy | ent_mask[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      dep_q    <= '0;
      end_seen <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      dep_q  <= dep_nxt;
      // a flushed end marker lets the program resume
      if (flush) begin
        if (end_buf)
          end_seen <= 1'b0;
      end else if (push && ex_sim_end) begin
        end_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= ent_in;
    end
  end

endmodule

// File: tb/tb_mod_exwb_issue.sv
// Bench for mod_exwb_issue: directed steps plus random traffic
// against a queue-based model of the buffer.
module tb_mod_exwb_issue;
  import pkg_pipeline::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        flush = 1'b0;
  logic        wb_ready = 1'b0;
  logic        can_writeback;
  EX_WB        exwb;
  logic [1:0]  dep_exwb;
  logic [15:0] dest_busy;
  EX_WB        cur = '0;

  mod_exwb_issue #(.DEPTH(DEPTH), .NREG(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_pc            (cur.pc),
    .ex_alu_result    (cur.alu_result),
    .ex_alu_ext_result(cur.alu_ext_result),
    .ex_opcode        (cur.opcode),
    .ex_regByte       (cur.reg_byte),
    .ex_rmByte        (cur.rm_byte),
    .ex_sim_end       (cur.sim_end),
    .flush            (flush),
    .wb_ready         (wb_ready),
    .can_writeback    (can_writeback),
    .exwb             (exwb),
    .dep_exwb         (dep_exwb),
    .dest_busy        (dest_busy)
  );

  always #5 clk = ~clk;

  EX_WB q[$];
  bit   m_end;
  bit   last_acc;
  int   checks = 0;
  int   errors = 0;
  int   npops = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_mask();
    logic [15:0] m = '0;
    foreach (q[i]) begin
      case (q[i].opcode)
        8'd247:  m |= 16'h0005;
        8'd255:  m |= 16'h0010;
        8'd137:  m |= 16'h0000;
        8'd139:  m |= 16'(1) << q[i].reg_byte;
        default: m |= 16'(1) << q[i].rm_byte;
      endcase
    end
    return m;
  endfunction

  function automatic EX_WB mk(input logic [7:0] op,
                              input logic [3:0] rg,
                              input logic [3:0] rm,
                              input logic se);
    EX_WB e;
    e.pc             = {$urandom, $urandom};
    e.alu_result     = {$urandom, $urandom};
    e.alu_ext_result = {$urandom, $urandom};
    e.opcode         = op;
    e.reg_byte       = rg;
    e.rm_byte        = rm;
    e.sim_end        = se;
    return e;
  endfunction

  task automatic check_all();
    int n = q.size();
    chk("ex_ready", 256'(ex_ready),
        256'(!reset && n < DEPTH && !m_end));
    chk("can_writeback", 256'(can_writeback), 256'(n != 0));
    chk("dep_exwb", 256'(dep_exwb), 256'(n > 3 ? 3 : n));
    chk("dest_busy", 256'(dest_busy), 256'(exp_mask()));
    if (n != 0)
      chk("exwb", 256'(exwb), 256'(q[0]));
  endtask

  task automatic model_edge();
    bit acc;
    last_acc = 1'b0;
    if (reset) begin
      q.delete();
      m_end = 1'b0;
      return;
    end
    acc = ex_valid && q.size() < DEPTH && !m_end;
    if (flush) begin
      foreach (q[i])
        if (q[i].sim_end) m_end = 1'b0;
      q.delete();
    end else begin
      if (q.size() != 0 && wb_ready) begin
        void'(q.pop_front());
        npops++;
      end
      if (acc) begin
        q.push_back(cur);
        last_acc = 1'b1;
        if (cur.sim_end) m_end = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_can_wb", 256'(can_writeback), 256'(0));
    chk("rst_dep", 256'(dep_exwb), 256'(0));
    chk("rst_busy", 256'(dest_busy), 256'(0));
    chk("rst_ready", 256'(ex_ready), 256'(0));
    chk("rst_exwb", 256'(exwb), 256'(0));
    q.delete();
    m_end = 1'b0;
    ex_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    // reset state
    cyc();
    chk("reset_exwb", 256'(exwb), 256'(0));
    reset = 1'b0;

    // single load, regByte=3, drained immediately
    cur = mk(8'd139, 4'd3, 4'd9, 1'b0);
    ex_valid = 1'b1;
    wb_ready = 1'b1;
    cyc();
    ex_valid = 1'b0;
    cyc();
    cyc();
    cyc();

    // stall: third offer waits for first pop
    wb_ready = 1'b0;
    ex_valid = 1'b1;
    cur = mk(8'd1, 4'd0, 4'd1, 1'b0);
    cyc();
    cur = mk(8'd2, 4'd0, 4'd6, 1'b0);
    cyc();
    cur = mk(8'd3, 4'd0, 4'd11, 1'b0);
    cyc();
    cyc();
    wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (last_acc) break;
    end
    chk("t2_third_acc", 256'(last_acc), 256'(1));
    ex_valid = 1'b0;
    repeat (3) cyc();

    // streaming: 10 results with push+pop each cycle
    p0 = npops;
    ex_valid = 1'b1;
    wb_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cur = mk(8'($urandom_range(0, 200)),
               4'($urandom), 4'($urandom), 1'b0);
      cyc();
    end
    ex_valid = 1'b0;
    repeat (2) cyc();
    chk("t3_pops", 256'(npops - p0), 256'(10));

    // dest mask for 247 + 255, then 137 alone
    wb_ready = 1'b0;
    ex_valid = 1'b1;
    cur = mk(8'd247, 4'd7, 4'd8, 1'b0);
    cyc();
    cur = mk(8'd255, 4'd7, 4'd8, 1'b0);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy_15", 256'(dest_busy), 256'(16'h0015));
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    repeat (3) cyc();
    wb_ready = 1'b0;
    ex_valid = 1'b1;
    cur = mk(8'd137, 4'd5, 4'd6, 1'b0);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy_0", 256'(dest_busy), 256'(0));
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    repeat (2) cyc();

    // sim_end blocks later pushes, drains normally
    wb_ready = 1'b0;
    ex_valid = 1'b1;
    cur = mk(8'd20, 4'd1, 4'd2, 1'b1);
    cyc();
    cur = mk(8'd21, 4'd1, 4'd2, 1'b0);
    repeat (3) cyc();
    wb_ready = 1'b1;
    repeat (3) cyc();
    chk("t5_blocked", 256'(ex_ready), 256'(0));
    async_reset();

    // flush of a full buffer beats push and pop
    wb_ready = 1'b0;
    ex_valid = 1'b1;
    cur = mk(8'd40, 4'd1, 4'd12, 1'b0);
    cyc();
    cur = mk(8'd41, 4'd1, 4'd13, 1'b0);
    cyc();
    p0 = npops;
    flush = 1'b1;
    wb_ready = 1'b1;
    cur = mk(8'd42, 4'd1, 4'd14, 1'b0);
    cyc();
    flush = 1'b0;
    ex_valid = 1'b0;
    cyc();
    chk("t6_no_pop", 256'(npops - p0), 256'(0));

    // mid-stream async reset
    ex_valid = 1'b1;
    wb_ready = 1'b0;
    cur = mk(8'd139, 4'd9, 4'd0, 1'b0);
    cyc();
    async_reset();
    cyc();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      int r = $urandom_range(0, 5);
      logic [7:0] op;
      case (r)
        0: op = 8'd247;
        1: op = 8'd255;
        2: op = 8'd137;
        3: op = 8'd139;
        default: op = 8'($urandom);
      endcase
      cur = mk(op, 4'($urandom), 4'($urandom),
               $urandom_range(0, 29) == 0);
      ex_valid = $urandom_range(0, 3) != 0;
      wb_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      if (m_end && q.size() == 0 && $urandom_range(0, 3) == 0)
        async_reset();
      else
        cyc();
    end
    ex_valid = 1'b0;
    flush = 1'b0;
    wb_ready = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
